// File: rtl/rc_axil_slave_regs_if.sv
// AXI4-Lite bus bundle between the processor/BFM master and the RC register bank.
// The slave modport is the register bank's view; the master modport is the driver's view.
interface rc_axil_slave_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/rc_axil_slave_regs.sv
// AXI4-Lite register bank: byte-strobed writes, 1-cycle registered reads, OKAY/SLVERR, one read and one write in flight.
// AW and W are captured independently and committed together; a stalled B or R channel only holds its own channel.
module rc_axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                 s00_axi_aclk,
    input  logic                                 s00_axi_areset,
    rc_axil_slave_regs_if.slave                  s00_axi,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0]                  reg_wr_pulse
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [31:0] NREGS = NUM_REGS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [IDX_W-1:0]     aw_idx_q;
    logic [DW-1:0]        w_data_q;
    logic [SW-1:0]        w_strb_q;
    logic                 aw_held, w_held;
    logic                 awready_q, wready_q, bvalid_q;
    logic [1:0]           bresp_q;
    logic                 arready_q, rvalid_q;
    logic [1:0]           rresp_q;
    logic [DW-1:0]        rdata_q;
    logic [DW*NUM_REGS-1:0] regs_q;
    logic [NUM_REGS-1:0]  pulse_q;

    logic                 aw_hs, w_hs, b_hs, ar_hs, commit;
    logic                 aw_held_d, w_held_d, bvalid_d, rvalid_d;
    logic                 wr_in_range, ar_in_range;
    logic [31:0]          aw_idx_ext, ar_idx_ext;
    logic [NUM_REGS-1:0]  wr_sel;
    logic [DW-1:0]        rd_val;
    logic                 unused_bits;

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = wready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;
    assign reg_out         = regs_q;
    assign reg_wr_pulse    = pulse_q;

    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                           s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    always_comb begin
        aw_hs     = s00_axi.awvalid & awready_q;
        w_hs      = s00_axi.wvalid & wready_q;
        b_hs      = bvalid_q & s00_axi.bready;
        ar_hs     = s00_axi.arvalid & arready_q;
        // Commit only from the held copies so AW/W arrival order does not matter.
        commit    = aw_held & w_held & ~bvalid_q;
        aw_held_d = b_hs ? 1'b0 : (aw_held | aw_hs);
        w_held_d  = b_hs ? 1'b0 : (w_held | w_hs);
        bvalid_d  = commit | (bvalid_q & ~s00_axi.bready);
        rvalid_d  = ar_hs | (rvalid_q & ~s00_axi.rready);

        aw_idx_ext  = 32'(aw_idx_q);
        ar_idx_ext  = 32'(s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]);
        wr_in_range = aw_idx_ext < NREGS;
        ar_in_range = ar_idx_ext < NREGS;

        wr_sel = '0;
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit && wr_in_range && aw_idx_ext == k) wr_sel[k] = 1'b1;
            if (ar_idx_ext == k) rd_val = regs_q[DW*k +: DW];
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            regs_q    <= '0;
            pulse_q   <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                w_data_q <= s00_axi.wdata;
                w_strb_q <= s00_axi.wstrb;
            end
            aw_held   <= aw_held_d;
            w_held    <= w_held_d;
            bvalid_q  <= bvalid_d;
            awready_q <= ~aw_held_d & ~bvalid_d;
            wready_q  <= ~w_held_d & ~bvalid_d;
            if (commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;

            for (int k = 0; k < NUM_REGS; k++) begin
                pulse_q[k] <= wr_sel[k] & (|w_strb_q);
                for (int b = 0; b < SW; b++) begin
                    if (wr_sel[k] && w_strb_q[b])
                        regs_q[DW*k + 8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // Read data samples the registers before any same-edge write lands.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            rvalid_q  <= rvalid_d;
            arready_q <= ~rvalid_d;
            if (ar_hs) begin
                rdata_q <= ar_in_range ? rd_val : '0;
                rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
endmodule

// File: tb/tb_rc_axil_slave_regs.sv
// Directed bench for rc_axil_slave_regs: write/readback table plus skew, stall, collision and reset sequences.
module tb_rc_axil_slave_regs;
    localparam int AW = 5;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    logic [32*NR-1:0] reg_out;
    logic [NR-1:0]    reg_wr_pulse;

    always #5 clk = ~clk;

    rc_axil_slave_regs_if #(.ADDR_W(AW), .DATA_W(32)) axi ();

    rc_axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi        (axi),
        .reg_out        (reg_out),
        .reg_wr_pulse   (reg_wr_pulse)
    );

    int n_cmp = 0;
    int n_err = 0;
    int pulse_hi = 0;

    always @(negedge clk) pulse_hi = pulse_hi + $countones(reg_wr_pulse);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        logic ah, wh;
        resp = 2'bxx;
        @(negedge clk);
        axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
        n = 0;
        while ((axi.awvalid || axi.wvalid) && n < 20) begin
            ah = axi.awvalid & axi.awready;
            wh = axi.wvalid & axi.wready;
            @(negedge clk);
            if (ah) axi.awvalid = 1'b0;
            if (wh) axi.wvalid = 1'b0;
            n++;
        end
        if (n >= 20) begin
            timeout("wr_addr_data");
            axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        end
        n = 0;
        while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("wr_bvalid");
        resp = axi.bresp;
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b0;
        n = 0;
        while (!axi.arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("rd_arready");
        @(negedge clk);
        axi.arvalid = 1'b0;
        n = 0;
        while (!axi.rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("rd_rvalid");
        d = axi.rdata;
        resp = axi.rresp;
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    // AW and W separated by three cycles, in either order; commit lands on the edge after the later one.
    task automatic skew_write(input bit aw_first, input logic [31:0] d);
        int p0;
        p0 = pulse_hi;
        axi.bready = 1'b0;
        axi.awaddr = 5'h08; axi.wdata = d; axi.wstrb = 4'hF;
        @(negedge clk);
        if (aw_first) axi.awvalid = 1'b1; else axi.wvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        chk("skew_first_ready_low", aw_first ? axi.awready : axi.wready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        if (aw_first) axi.wvalid = 1'b1; else axi.awvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        chk("skew_bvalid_early", {axi.bvalid, reg_wr_pulse}, 5'b0_0000);
        @(negedge clk);
        chk("skew_bvalid_pulse", {axi.bvalid, axi.bresp, reg_wr_pulse}, 7'b1_00_0100);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        chk("skew_pulse_count", pulse_hi - p0, 1);
        chk("skew_reg2", reg_out[64 +: 32], d);
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
        logic [1:0]    bresp;
        logic [31:0]   rdata;
        logic [1:0]    rresp;
        logic [1:0]    pulses;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    logic [31:0] rd;
    logic [1:0]  rr, br;
    int          p0;
    bit          stall_ok, rd_done;

    initial begin
        vecs[0] = '{5'h00, 32'h0101FFFF, 4'hF, 2'b00, 32'h0101FFFF, 2'b00, 2'd1};
        vecs[1] = '{5'h04, 32'hABCD0001, 4'hF, 2'b00, 32'hABCD0001, 2'b00, 2'd1};
        vecs[2] = '{5'h08, 32'hDEAD0011, 4'hF, 2'b00, 32'hDEAD0011, 2'b00, 2'd1};
        vecs[3] = '{5'h0C, 32'hBEEF0011, 4'hF, 2'b00, 32'hBEEF0011, 2'b00, 2'd1};
        vecs[4] = '{5'h00, 32'h12345678, 4'h3, 2'b00, 32'h01015678, 2'b00, 2'd1};
        vecs[5] = '{5'h10, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h00000000, 2'b10, 2'd0};
        vecs[6] = '{5'h04, 32'h55555555, 4'h0, 2'b00, 32'hABCD0001, 2'b00, 2'd0};
        vecs[7] = '{5'h08, 32'h0000AA00, 4'h2, 2'b00, 32'hDEADAA11, 2'b00, 2'd1};
        vecs[8] = '{5'h1C, 32'h13579BDF, 4'hF, 2'b10, 32'h00000000, 2'b10, 2'd0};

        rst = 1'b1;
        axi.awaddr = '0; axi.awprot = 3'b0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = 3'b0; axi.arvalid = 1'b0; axi.rready = 1'b0;

        // Reset state and ready release
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {axi.awready, axi.wready, axi.bvalid, axi.bresp,
                         axi.arready, axi.rvalid, axi.rresp}, 9'b0);
        chk("rst_rdata", axi.rdata, 32'h0);
        chk("rst_regs", 64'($countones(reg_out)) + 64'($countones(reg_wr_pulse)), 0);
        rst = 1'b0;
        #1 chk("readys_before_edge", {axi.awready, axi.wready, axi.arready}, 3'b000);
        @(negedge clk);
        chk("readys_after_edge", {axi.awready, axi.wready, axi.arready}, 3'b111);

        // Write / read-back table
        for (int i = 0; i < NV; i++) begin
            p0 = pulse_hi;
            do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, br);
            chk($sformatf("v%0d_bresp", i), br, vecs[i].bresp);
            chk($sformatf("v%0d_pulses", i), pulse_hi - p0, vecs[i].pulses);
            do_read(vecs[i].addr, rd, rr);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_rresp", i), rr, vecs[i].rresp);
        end
        chk("regout0", reg_out[0  +: 32], 32'h01015678);
        chk("regout1", reg_out[32 +: 32], 32'hABCD0001);
        chk("regout2", reg_out[64 +: 32], 32'hDEADAA11);
        chk("regout3", reg_out[96 +: 32], 32'hBEEF0011);

        skew_write(1'b1, 32'h01234567);
        skew_write(1'b0, 32'h89ABCDEF);

        // Read AR handshake on the same edge as a commit to that register
        @(negedge clk);
        axi.awaddr = 5'h04; axi.wdata = 32'h11112222; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 5'h04; axi.arvalid = 1'b1; axi.rready = 1'b0;
        @(negedge clk);
        axi.arvalid = 1'b0;
        chk("coll_old_value", {axi.rvalid, axi.bvalid, axi.rdata}, {2'b11, 32'hABCD0001});
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0; axi.bready = 1'b0;
        do_read(5'h04, rd, rr);
        chk("coll_new_value", rd, 32'h11112222);

        // bready held low; reads proceed meanwhile
        @(negedge clk);
        axi.awaddr = 5'h0C; axi.wdata = 32'h0F0F0F0F; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(negedge clk);
        stall_ok = 1'b1;
        rd_done = 1'b0;
        fork
            begin
                for (int c = 0; c < 5; c++) begin
                    if (!(axi.bvalid && axi.bresp == 2'b00 && !axi.awready && !axi.wready))
                        stall_ok = 1'b0;
                    @(negedge clk);
                end
                chk("stall_read_not_blocked", rd_done, 1'b1);
            end
            begin
                do_read(5'h04, rd, rr);
                rd_done = 1'b1;
            end
        join
        chk("stall_b_held", stall_ok, 1'b1);
        chk("stall_read_data", {rr, rd}, {2'b00, 32'h11112222});
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        chk("stall_b_released", axi.bvalid, 1'b0);
        @(negedge clk);
        chk("stall_readys_back", {axi.awready, axi.wready}, 2'b11);
        do_read(5'h0C, rd, rr);
        chk("stall_reg3", rd, 32'h0F0F0F0F);

        // Reset mid-transaction: AW held, read response pending
        @(negedge clk);
        axi.awaddr = 5'h04; axi.awvalid = 1'b1;
        axi.araddr = 5'h00; axi.arvalid = 1'b1; axi.rready = 1'b0;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.arvalid = 1'b0;
        chk("pre_rst_pending", {axi.awready, axi.rvalid}, 2'b01);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", {axi.awready, axi.wready, axi.bvalid, axi.bresp,
                            axi.arready, axi.rvalid, axi.rresp}, 9'b0);
        chk("midrst_data", 64'($countones(reg_out)) + 64'($countones(reg_wr_pulse))
                           + 64'($countones(axi.rdata)), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_write(5'h04, 32'hCAFEF00D, 4'hF, br);
        chk("post_rst_bresp", br, 2'b00);
        do_read(5'h04, rd, rr);
        chk("post_rst_read", {rr, rd}, {2'b00, 32'hCAFEF00D});
        do_read(5'h00, rd, rr);
        chk("post_rst_reg0", {rr, rd}, {2'b00, 32'h00000000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
